// File: rtl/mii_rx_pkg.sv
// Shared FSM state type and framing/CRC constants for the MII receive framer.
package mii_rx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRE,
      DATA,
      DROP
   } rx_state_t;

   localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
   localparam logic [3:0]  SFD_NIB      = 4'hD;
   localparam logic [31:0] CRC_POLY     = 32'h04C11DB7;
   localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;

   function automatic logic [31:0] reflect32(input logic [31:0] v);
      logic [31:0] r;
      for (int unsigned i = 0; i < 32; i++) begin
         r[i] = v[31 - i];
      end
      return r;
   endfunction

endpackage

// File: rtl/mii_rx_framer_crc32_d8.sv
// Combinational byte-wide CRC-32 step (LSB-first, reflected register).
// Only built when MII_RX_CRC_CHECK_EN is defined.
`ifdef MII_RX_CRC_CHECK_EN
module crc32_d8
   import mii_rx_pkg::*;
(
   input  logic [31:0] crc,
   input  logic [7:0]  data,
   output logic [31:0] crc_next
);

   localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

   always_comb begin
      crc_next = crc;
      for (int unsigned i = 0; i < 8; i++) begin
         if (crc_next[0] ^ data[i]) begin
            crc_next = (crc_next >> 1) ^ POLY_REFL;
         end else begin
            crc_next = crc_next >> 1;
         end
      end
   end

endmodule
`endif

// File: rtl/mii_rx_framer.sv
// MAC-side MII receive framer: strips preamble/SFD, packs nibbles into bytes, flags bad frames.
// Optional FCS check enabled by defining MII_RX_CRC_CHECK_EN.
module mii_rx_framer
   import mii_rx_pkg::*;
#(
   parameter int unsigned MIN_LEN = 64,
   parameter int unsigned MAX_LEN = 1522
) (
   input  logic       mac_mii_rxc,
   input  logic       rstn,
   input  logic       mac_mii_rxdv,
   input  logic       mac_mii_rxer,
   input  logic [3:0] mac_mii_rxd,
   output logic       o_valid,
   output logic [7:0] o_data,
   output logic       o_last,
   output logic       o_err,
   output logic       stat_ok,
   output logic       stat_bad
);

   localparam logic [10:0] MIN_CNT = 11'(MIN_LEN);
   localparam logic [10:0] MAX_CNT = 11'(MAX_LEN);

   rx_state_t   state, state_n;
   logic        nib_odd, nib_odd_n;
   logic [3:0]  low_nib, low_nib_n;
   logic        hold_valid, hold_valid_n;
   logic [7:0]  hold_byte, hold_byte_n;
   logic [10:0] byte_cnt, byte_cnt_n;
   logic        frame_err, frame_err_n;
   logic        valid_n, last_n, err_out_n, ok_n, bad_n;
   logic [7:0]  data_n;
   logic [7:0]  new_byte;
   logic        crc_bad;
   logic        end_bad;

   assign new_byte = {mac_mii_rxd, low_nib};

`ifdef MII_RX_CRC_CHECK_EN
   logic [31:0] crc, crc_n, crc_step;

   crc32_d8 u_crc (
      .crc      (crc),
      .data     (new_byte),
      .crc_next (crc_step)
   );

   // Register holds the reflected CRC, so compare against the bit-reversed magic residue.
   assign crc_bad = (reflect32(crc) != CRC_RESIDUE);

   always_ff @(posedge mac_mii_rxc or negedge rstn) begin
      if (!rstn) crc <= CRC_INIT;
      else       crc <= crc_n;
   end
`else
   assign crc_bad = 1'b0;
`endif

   assign end_bad = frame_err | nib_odd | (byte_cnt < MIN_CNT) | crc_bad;

   always_comb begin
      state_n      = state;
      nib_odd_n    = nib_odd;
      low_nib_n    = low_nib;
      hold_valid_n = hold_valid;
      hold_byte_n  = hold_byte;
      byte_cnt_n   = byte_cnt;
      frame_err_n  = frame_err;
      valid_n      = 1'b0;
      data_n       = '0;
      last_n       = 1'b0;
      err_out_n    = 1'b0;
      ok_n         = 1'b0;
      bad_n        = 1'b0;
`ifdef MII_RX_CRC_CHECK_EN
      crc_n        = crc;
`endif
      unique case (state)
         IDLE: begin
            if (mac_mii_rxdv) begin
               if (mac_mii_rxd == PREAMBLE_NIB) begin
                  state_n = PRE;
               end else begin
                  state_n = DROP;
                  bad_n   = 1'b1;
               end
            end
         end
         PRE: begin
            if (!mac_mii_rxdv) begin
               state_n = IDLE;
               bad_n   = 1'b1;
            end else if (mac_mii_rxd == SFD_NIB) begin
               state_n      = DATA;
               nib_odd_n    = 1'b0;
               hold_valid_n = 1'b0;
               byte_cnt_n   = '0;
               frame_err_n  = 1'b0;
`ifdef MII_RX_CRC_CHECK_EN
               crc_n        = CRC_INIT;
`endif
            end else if (mac_mii_rxd != PREAMBLE_NIB) begin
               state_n = DROP;
               bad_n   = 1'b1;
            end
         end
         DATA: begin
            if (!mac_mii_rxdv) begin
               state_n      = IDLE;
               hold_valid_n = 1'b0;
               if (hold_valid) begin
                  valid_n   = 1'b1;
                  data_n    = hold_byte;
                  last_n    = 1'b1;
                  err_out_n = end_bad;
                  ok_n      = !end_bad;
                  bad_n     = end_bad;
               end else begin
                  bad_n = 1'b1;
               end
            end else if (byte_cnt == MAX_CNT) begin
               state_n      = DROP;
               hold_valid_n = 1'b0;
               valid_n      = 1'b1;
               data_n       = hold_byte;
               last_n       = 1'b1;
               err_out_n    = 1'b1;
               bad_n        = 1'b1;
            end else begin
               if (mac_mii_rxer) frame_err_n = 1'b1;
               if (!nib_odd) begin
                  low_nib_n = mac_mii_rxd;
                  nib_odd_n = 1'b1;
               end else begin
                  nib_odd_n    = 1'b0;
                  valid_n      = hold_valid;
                  data_n       = hold_valid ? hold_byte : '0;
                  hold_byte_n  = new_byte;
                  hold_valid_n = 1'b1;
                  if (byte_cnt != '1) byte_cnt_n = byte_cnt + 11'd1;
`ifdef MII_RX_CRC_CHECK_EN
                  crc_n        = crc_step;
`endif
               end
            end
         end
         DROP: begin
            if (!mac_mii_rxdv) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge mac_mii_rxc or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         nib_odd    <= 1'b0;
         low_nib    <= '0;
         hold_valid <= 1'b0;
         hold_byte  <= '0;
         byte_cnt   <= '0;
         frame_err  <= 1'b0;
         o_valid    <= 1'b0;
         o_data     <= '0;
         o_last     <= 1'b0;
         o_err      <= 1'b0;
         stat_ok    <= 1'b0;
         stat_bad   <= 1'b0;
      end else begin
         state      <= state_n;
         nib_odd    <= nib_odd_n;
         low_nib    <= low_nib_n;
         hold_valid <= hold_valid_n;
         hold_byte  <= hold_byte_n;
         byte_cnt   <= byte_cnt_n;
         frame_err  <= frame_err_n;
         o_valid    <= valid_n;
         o_data     <= data_n;
         o_last     <= last_n;
         o_err      <= err_out_n;
         stat_ok    <= ok_n;
         stat_bad   <= bad_n;
      end
   end

endmodule

// File: tb/tb_mii_rx_framer.sv
// Directed bench for mii_rx_framer: frame-level reference model plus per-cycle beat checks.
module tb_mii_rx_framer;

   localparam int MIN_LEN = 64;
   localparam int MAX_LEN = 1522;

   logic       clk  = 1'b0;
   logic       rstn = 1'b0;
   logic       rxdv = 1'b0;
   logic       rxer = 1'b0;
   logic [3:0] rxd  = '0;
   logic       o_valid, o_last, o_err, stat_ok, stat_bad;
   logic [7:0] o_data;

   typedef struct {
      logic [7:0] data;
      logic       last;
      logic       err;
   } beat_t;

   beat_t      exp_q[$];
   logic [3:0] nq[$];
   logic       eq[$];
   logic [7:0] fb[$];

   int   errors = 0, checks = 0;
   int   exp_ok = 0, exp_bad = 0, got_ok = 0, got_bad = 0, beats_seen = 0;
   logic last_err_seen;

   always #20 clk = ~clk;

   mii_rx_framer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
      .mac_mii_rxc  (clk),
      .rstn         (rstn),
      .mac_mii_rxdv (rxdv),
      .mac_mii_rxer (rxer),
      .mac_mii_rxd  (rxd),
      .o_valid      (o_valid),
      .o_data       (o_data),
      .o_last       (o_last),
      .o_err        (o_err),
      .stat_ok      (stat_ok),
      .stat_bad     (stat_bad)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   always @(negedge clk) begin
      beat_t e;
      if (rstn) begin
         if (stat_ok)  got_ok++;
         if (stat_bad) got_bad++;
         if (o_valid) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
               check("unexpected_beat", {24'h0, o_data}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("beat_data", {24'h0, o_data}, {24'h0, e.data});
               check("beat_last", {31'h0, o_last}, {31'h0, e.last});
               if (e.last) begin
                  check("beat_err", {31'h0, o_err}, {31'h0, e.err});
                  last_err_seen = o_err;
               end
            end
         end
      end
   end

   // Ethernet CRC-32 as transmitted (final inversion applied).
   function automatic logic [31:0] crc32_std(input logic [7:0] b[$], input int n);
      logic [31:0] c = 32'hFFFF_FFFF;
      for (int k = 0; k < n; k++) begin
         c = c ^ {24'h0, b[k]};
         for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic add_fcs();
      logic [31:0] c;
      c = crc32_std(fb, fb.size());
      fb.push_back(c[7:0]);
      fb.push_back(c[15:8]);
      fb.push_back(c[23:16]);
      fb.push_back(c[31:24]);
   endtask

   task automatic fill_payload(input int n, input logic [7:0] base);
      fb.delete();
      for (int k = 0; k < n; k++) fb.push_back(8'(base + k));
   endtask

   task automatic put_nib(input logic [3:0] n);
      nq.push_back(n);
      eq.push_back(1'b0);
   endtask

   task automatic put_pre();
      for (int k = 0; k < 15; k++) put_nib(4'h5);
      put_nib(4'hD);
   endtask

   task automatic put_bytes();
      foreach (fb[k]) begin
         put_nib(fb[k][3:0]);
         put_nib(fb[k][7:4]);
      end
   endtask

   task automatic drive(input logic dv, input logic er, input logic [3:0] d);
      rxdv = dv;
      rxer = er;
      rxd  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic send_stream(input int gap);
      int         n, i, nb;
      logic       odd, rxe, bad;
      logic [7:0] b[$];
      n   = nq.size();
      nb  = -1;
      odd = 1'b0;
      rxe = 1'b0;
      if (n > 0 && nq[0] == 4'h5) begin
         i = 1;
         while (i < n && nq[i] == 4'h5) i++;
         if (i < n && nq[i] == 4'hD) begin
            i++;
            nb  = (n - i) / 2;
            odd = ((n - i) % 2) != 0;
            for (int k = i; k < n; k++) if (eq[k]) rxe = 1'b1;
            for (int k = 0; k < nb; k++) b.push_back({nq[i + 2*k + 1], nq[i + 2*k]});
         end
      end
      if (nb <= 0) begin
         exp_bad++;
      end else if (nb > MAX_LEN) begin
         for (int k = 0; k < MAX_LEN; k++) exp_q.push_back('{data: b[k], last: (k == MAX_LEN - 1), err: 1'b1});
         exp_bad++;
      end else begin
         bad = rxe | odd | (nb < MIN_LEN);
`ifdef MII_RX_CRC_CHECK_EN
         begin
            logic [31:0] c, fcs;
            if (nb < 4) bad = 1'b1;
            else begin
               c   = crc32_std(b, nb - 4);
               fcs = {b[nb-1], b[nb-2], b[nb-3], b[nb-4]};
               if (c != fcs) bad = 1'b1;
            end
         end
`endif
         for (int k = 0; k < nb; k++) exp_q.push_back('{data: b[k], last: (k == nb - 1), err: bad});
         if (bad) exp_bad++;
         else     exp_ok++;
      end
      for (int k = 0; k < n; k++) drive(1'b1, eq[k], nq[k]);
      for (int k = 0; k < gap; k++) drive(1'b0, 1'b0, 4'h0);
      nq.delete();
      eq.delete();
   endtask

   task automatic settle(input string name);
      for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 4'h0);
      check({name, "_drained"}, exp_q.size(), 0);
      check({name, "_stat_ok"}, got_ok, exp_ok);
      check({name, "_stat_bad"}, got_bad, exp_bad);
   endtask

   task automatic start_frame();
      beats_seen    = 0;
      last_err_seen = 1'bx;
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      check("rst_valid", {31'h0, o_valid}, 0);
      check("rst_data", {24'h0, o_data}, 0);
      check("rst_last", {31'h0, o_last}, 0);
      check("rst_err", {31'h0, o_err}, 0);
      check("rst_ok", {31'h0, stat_ok}, 0);
      check("rst_bad", {31'h0, stat_bad}, 0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      drive(1'b0, 1'b0, 4'h0);

      // 64 bytes + FCS, good
      start_frame();
      fill_payload(64, 8'h00); add_fcs(); put_pre(); put_bytes();
      send_stream(2); settle("t1");
      check("t1_beats", beats_seen, 68);
      check("t1_err", {31'h0, last_err_seen}, 0);
      check("t1_ok_count", got_ok, 1);

      // rxer on one nibble of byte 10
      start_frame();
      fill_payload(64, 8'h00); add_fcs(); put_pre(); put_bytes();
      eq[16 + 20] = 1'b1;
      send_stream(2); settle("t2");
      check("t2_beats", beats_seen, 68);
      check("t2_err", {31'h0, last_err_seen}, 1);

      // bad preamble, then preamble cut short, then a 60-byte runt
      start_frame();
      put_nib(4'h5); put_nib(4'h5); put_nib(4'h5); put_nib(4'hA); put_nib(4'h5); put_nib(4'h5);
      send_stream(2);
      put_nib(4'h5); put_nib(4'h5); put_nib(4'h5);
      send_stream(2); settle("t3a");
      check("t3a_beats", beats_seen, 0);
      check("t3a_bad_count", got_bad, 3);
      start_frame();
      fill_payload(60, 8'h80); put_nib(4'h5); put_nib(4'hD); put_bytes();
      send_stream(2); settle("t3b");
      check("t3b_beats", beats_seen, 60);
      check("t3b_err", {31'h0, last_err_seen}, 1);

      // 63-byte frame with valid FCS: one short of minimum
      start_frame();
      fill_payload(59, 8'h11); add_fcs(); put_pre(); put_bytes();
      send_stream(2); settle("t3c");
      check("t3c_err", {31'h0, last_err_seen}, 1);

      // oversize frame truncated, followed by good frame
      start_frame();
      fill_payload(1530, 8'h20); put_pre(); put_bytes();
      send_stream(2); settle("t4");
      check("t4_beats", beats_seen, 1522);
      check("t4_err", {31'h0, last_err_seen}, 1);

      // exactly MAX_LEN bytes is not truncation
      start_frame();
      fill_payload(1518, 8'h40); add_fcs(); put_pre(); put_bytes();
      send_stream(2); settle("t4b");
      check("t4b_beats", beats_seen, 1522);
      check("t4b_err", {31'h0, last_err_seen}, 0);

      // dribble nibble
      start_frame();
      fill_payload(64, 8'h00); add_fcs(); put_pre(); put_bytes(); put_nib(4'h7);
      send_stream(2); settle("t5");
      check("t5_beats", beats_seen, 68);
      check("t5_err", {31'h0, last_err_seen}, 1);

      // payload bit flipped after FCS computed
      start_frame();
      fill_payload(64, 8'h00); add_fcs(); fb[5] = fb[5] ^ 8'h10; put_pre(); put_bytes();
      send_stream(2); settle("t6");
`ifdef MII_RX_CRC_CHECK_EN
      check("t6_err", {31'h0, last_err_seen}, 1);
`else
      check("t6_err", {31'h0, last_err_seen}, 0);
`endif

      // empty frame: rxdv falls right after SFD
      start_frame();
      put_pre();
      send_stream(2); settle("t7");
      check("t7_beats", beats_seen, 0);

      // back-to-back frames, one idle cycle apart
      start_frame();
      fill_payload(64, 8'h30); add_fcs(); put_pre(); put_bytes();
      send_stream(1);
      fill_payload(70, 8'h55); add_fcs(); put_pre(); put_bytes();
      send_stream(2); settle("t8");
      check("t8_beats", beats_seen, 142);

      // reset in mid-frame: earlier bytes already out, held byte and stats lost
      start_frame();
      fill_payload(5, 8'hA0); put_pre(); put_bytes();
      for (int k = 0; k < 4; k++) exp_q.push_back('{data: fb[k], last: 1'b0, err: 1'b0});
      for (int k = 0; k < nq.size(); k++) drive(1'b1, 1'b0, nq[k]);
      nq.delete(); eq.delete();
      @(negedge clk);
      #1;
      rstn = 1'b0;
      rxdv = 1'b0;
      @(negedge clk);
      check("rst2_valid", {31'h0, o_valid}, 0);
      check("rst2_last", {31'h0, o_last}, 0);
      check("rst2_bad", {31'h0, stat_bad}, 0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      settle("t9");
      check("t9_beats", beats_seen, 4);

      // clean frame after reset
      start_frame();
      fill_payload(64, 8'hC0); add_fcs(); put_pre(); put_bytes();
      send_stream(2); settle("t10");
      check("t10_err", {31'h0, last_err_seen}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
